// File: rtl/sha1_arb_pkg.sv
// Shared types and constants for the sha1 core arbiter.
package sha1_arb_pkg;

  localparam int unsigned BlockW   = 512;
  localparam int unsigned DigestW  = 160;
  localparam int unsigned MinDrain = 2;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRun,
    StDrain
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching upward from last+1.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  logic [NUM_REQ-1:0] w_rot;
  int unsigned        w_off;
  int unsigned        w_sum;

  // Rotate so that bit 0 is requester last+1; a shift of NUM_REQ yields req unchanged.
  assign w_rot = NUM_REQ'({req, req} >> (32'(last) + 32'd1));

  always_comb begin
    valid = 1'b0;
    w_off = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!valid && w_rot[k]) begin
        valid = 1'b1;
        w_off = k;
      end
    end
    w_sum = 32'(last) + 32'd1 + w_off;
    if (w_sum >= NUM_REQ) begin
      w_sum = w_sum - NUM_REQ;
    end
    idx = ID_W'(w_sum);
  end

endmodule

// File: rtl/sha1_arbiter.sv
// Round-robin scheduler sharing one sha1 core among NUM_REQ requesters.
module sha1_arbiter
  import sha1_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned TIMEOUT      = 1023,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*BlockW-1:0] block_in,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [DigestW-1:0]        digest_out,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      core_on,
  output logic [BlockW-1:0]         core_message,
  input  logic                      core_finish,
  input  logic [DigestW-1:0]        core_digest
);

  localparam int unsigned DrainN = (DRAIN_CYCLES < MinDrain) ? MinDrain : DRAIN_CYCLES;
  localparam int unsigned TcntW  = $clog2(TIMEOUT + 1);
  localparam int unsigned DcntW  = $clog2(DrainN + 1);
  localparam logic [TcntW-1:0]   TcntMax = TcntW'(TIMEOUT);
  localparam logic [DcntW-1:0]   DcntMax = DcntW'(DrainN);
  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LastRst = ID_W'(NUM_REQ - 1);

  arb_state_e          r_state;
  logic [ID_W-1:0]     r_grant_id;
  logic [ID_W-1:0]     r_last;
  logic [BlockW-1:0]   r_core_message;
  logic [DigestW-1:0]  r_digest;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REQ-1:0]  r_err;
  logic                r_core_on;
  logic [TcntW-1:0]    r_tcnt;
  logic [DcntW-1:0]    r_dcnt;

  logic                w_valid;
  logic [ID_W-1:0]     w_idx;
  logic [BlockW-1:0]   w_block;
  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [NUM_REQ-1:0]  w_grant_oh;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req   (req),
    .last  (r_last),
    .valid (w_valid),
    .idx   (w_idx)
  );

  assign w_block    = block_in[32'(w_idx) * BlockW +: BlockW];
  assign w_pick_oh  = OneHot0 << w_idx;
  assign w_grant_oh = OneHot0 << r_grant_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_grant_id     <= '0;
      r_last         <= LastRst;
      r_core_message <= '0;
      r_digest       <= '0;
      r_ack          <= '0;
      r_done         <= '0;
      r_err          <= '0;
      r_core_on      <= 1'b0;
      r_tcnt         <= '0;
      r_dcnt         <= '0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_valid) begin
            r_grant_id     <= w_idx;
            r_last         <= w_idx;
            r_core_message <= w_block;
            r_ack          <= w_pick_oh;
            r_core_on      <= 1'b1;
            r_state        <= StGrant;
          end
        end
        StGrant: begin
          r_tcnt  <= '0;
          r_state <= StRun;
        end
        StRun: begin
          // Finish takes priority over a timeout landing on the same cycle.
          if (core_finish) begin
            r_digest  <= core_digest;
            r_done    <= w_grant_oh;
            r_core_on <= 1'b0;
            r_dcnt    <= '0;
            r_state   <= StDrain;
          end else if (r_tcnt == TcntMax) begin
            r_err     <= w_grant_oh;
            r_core_on <= 1'b0;
            r_dcnt    <= '0;
            r_state   <= StDrain;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        StDrain: begin
          // The done/err cycle is followed by DRAIN_CYCLES quiet cycles with core_on low.
          if (r_dcnt == DcntMax) begin
            r_state <= StIdle;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ack          = r_ack;
  assign done         = r_done;
  assign err          = r_err;
  assign digest_out   = r_digest;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state != StIdle);
  assign core_on      = r_core_on;
  assign core_message = r_core_message;

endmodule

// File: tb/tb_sha1_arbiter.sv
// Scoreboard bench for sha1_arbiter with a latency-programmable core stub.
module tb_sha1_arbiter;

  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int TMO   = 300;
  localparam int DRN   = 2;
  localparam int Never = 100000;

  typedef struct {
    int           kind;  // 0 ack, 1 done, 2 err
    int           id;
    logic [159:0] dig;
    int           lat;   // cycles from ack to done/err
    int           gap;   // cycles from previous done/err to this ack, -1 = unchecked
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [N*512-1:0] block_in;
  logic [N-1:0]     ack, done, err;
  logic [159:0]     digest_out;
  logic [IDW-1:0]   grant_id;
  logic             busy, core_on;
  logic [511:0]     core_message;
  logic             core_finish;
  logic [159:0]     core_digest;

  int           total = 0;
  int           bad = 0;
  int           lat = 20;
  int           scnt = 0;
  exp_t         exp_q[$];
  logic [511:0] drv_q[N][$];
  logic [511:0] mdl_q[N][$];
  int           m_last;
  logic [159:0] m_dig;

  always #5 clk = ~clk;

  sha1_arbiter #(
    .NUM_REQ      (N),
    .ID_W         (IDW),
    .TIMEOUT      (TMO),
    .DRAIN_CYCLES (DRN)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .block_in     (block_in),
    .ack          (ack),
    .done         (done),
    .err          (err),
    .digest_out   (digest_out),
    .grant_id     (grant_id),
    .busy         (busy),
    .core_on      (core_on),
    .core_message (core_message),
    .core_finish  (core_finish),
    .core_digest  (core_digest)
  );

  // Core stub: finish rises lat cycles after on rises, clears when on drops.
  always @(posedge clk) begin
    if (!core_on) scnt <= 0;
    else          scnt <= scnt + 1;
  end
  assign core_finish = core_on && (scnt >= lat);
  assign core_digest = {5{core_message[31:0]}};

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [511:0] rblk();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic int oh2id(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic add_drv(input int i, input logic [511:0] b);
    drv_q[i].push_back(b);
  endtask

  task automatic add_mdl(input int i, input logic [511:0] b);
    mdl_q[i].push_back(b);
  endtask

  task automatic add_job(input int i, input logic [511:0] b);
    add_drv(i, b);
    add_mdl(i, b);
  endtask

  // Reference: serve model jobs round-robin from m_last and queue the expected events.
  task automatic plan(input bit gap_first);
    bit           first = 1'b1;
    int           j;
    logic [511:0] b;
    exp_t         e;
    while (1) begin
      j = -1;
      for (int k = 1; k <= N; k++) begin
        int c = (m_last + k) % N;
        if (j < 0 && mdl_q[c].size() > 0) j = c;
      end
      if (j < 0) break;
      b      = mdl_q[j].pop_front();
      m_last = j;
      e.kind = 0;
      e.id   = j;
      e.dig  = '0;
      e.lat  = 0;
      e.gap  = (first && !gap_first) ? -1 : DRN + 2;
      exp_q.push_back(e);
      if (lat <= TMO + 1) begin
        m_dig  = {5{b[31:0]}};
        e.kind = 1;
        e.lat  = lat + 1;
      end else begin
        e.kind = 2;
        e.lat  = TMO + 2;
      end
      e.dig = m_dig;
      e.gap = 0;
      exp_q.push_back(e);
      first = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (DRN + 4) @(negedge clk);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ack"}, ack, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_core_on"}, core_on, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_digest"}, digest_out, 0);
    chk({nm, "_message"}, core_message, 0);
    chk({nm, "_grant_id"}, grant_id, 0);
  endtask

  // Requesters: hold req while jobs remain, advance to the next block on ack.
  initial begin
    req      = '0;
    block_in = '0;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (ack[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        req[i] = (drv_q[i].size() > 0);
        block_in[i*512 +: 512] = (drv_q[i].size() > 0) ? drv_q[i][0] : '0;
      end
    end
  end

  // Monitor: pop and compare on every ack/done/err.
  initial begin
    int   cyc = 0;
    int   ack_cyc = 0;
    int   end_cyc = -100;
    int   id;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        end_cyc = -100;
      end else begin
        if (end_cyc >= 0 && cyc > end_cyc && cyc <= end_cyc + DRN + 1)
          chk("drain_core_on", core_on, 0);
        if ((ack | done | err) != '0) begin
          chk("one_event", $countones({ack, done, err}), 1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got ack=%b done=%b err=%b want none", ack, done, err);
          end else begin
            e = exp_q.pop_front();
            if (ack != '0) begin
              id = oh2id(ack);
              chk("ack_kind", 0, e.kind);
              chk("ack_id", id, e.id);
              chk("ack_grant_id", grant_id, e.id);
              chk("ack_core_on", core_on, 1);
              if (e.gap >= 0) chk("ack_gap", cyc - end_cyc, e.gap);
              ack_cyc = cyc;
            end else begin
              id = oh2id(done | err);
              chk("end_kind", (done != '0) ? 1 : 2, e.kind);
              chk("end_id", id, e.id);
              chk("end_digest", digest_out, e.dig);
              chk("end_latency", cyc - ack_cyc, e.lat);
              chk("end_core_on", core_on, 0);
              end_cyc = cyc;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [511:0] b;
    int           n;
    bit           any;
    reset_n = 1'b0;
    m_last  = N - 1;
    m_dig   = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    reset_n = 1'b1;
    @(negedge clk);

    // Single request with a known first word.
    lat = 240;
    b = rblk();
    b[31:0] = 32'h61626380;
    add_job(0, b);
    plan(1'b0);
    @(negedge clk);
    chk("single_ack_latency", ack, 4'b0001);
    wait_idle("single");
    chk("single_digest", digest_out, {5{32'h61626380}});

    // All requesters at once, requester 0 with two jobs.
    lat = 40;
    for (int i = 0; i < N; i++) add_job(i, rblk());
    add_job(0, rblk());
    plan(1'b0);
    wait_idle("simul");

    // Fairness: req0 stays high, req2 arrives during job 0.
    lat = 30;
    add_job(0, rblk());
    b = rblk();
    add_drv(0, b);
    plan(1'b0);
    n = 0;
    while (!ack[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fair_first_ack", ack[0], 1);
    add_mdl(0, b);
    add_job(2, rblk());
    plan(1'b1);
    wait_idle("fair");

    // Timeout, then a normal job.
    lat = Never;
    add_job(1, rblk());
    plan(1'b0);
    wait_idle("timeout");
    chk("timeout_digest_held", digest_out, m_dig);
    lat = 25;
    add_job(3, rblk());
    plan(1'b0);
    wait_idle("after_timeout");

    // Finish exactly on the timeout cycle, then one cycle too late.
    lat = TMO + 1;
    add_job(2, rblk());
    plan(1'b0);
    wait_idle("finish_on_timeout");
    lat = TMO + 2;
    add_job(0, rblk());
    plan(1'b0);
    wait_idle("finish_late");

    // Random mixes.
    for (int r = 0; r < 4; r++) begin
      lat = $urandom_range(1, 60);
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        int c = $urandom_range(0, 2);
        for (int k = 0; k < c; k++) begin
          add_job(i, rblk());
          any = 1'b1;
        end
      end
      if (!any) add_job($urandom_range(0, N - 1), rblk());
      plan(1'b0);
      wait_idle("rand");
    end

    // Reset in the middle of a running job.
    lat = Never;
    add_drv(2, rblk());
    exp_q.push_back('{kind: 0, id: 2, dig: '0, lat: 0, gap: -1});
    n = 0;
    while (!ack[2] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midrun_ack", ack[2], 1);
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    #2;
    chk_reset("midrun");
    chk("midrun_queue", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    m_last  = N - 1;
    m_dig   = '0;
    lat     = 20;
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) add_job(i, rblk());
    plan(1'b0);
    wait_idle("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
